// File: rtl/tt_um_jimktrains_vslc_sequencer.sv
// ---------------------------------------------------------------------------
// tt_um_jimktrains_vslc_sequencer
//
// Scan sequencer for a VSLC (very small logic controller). It holds a
// 16 x 8 program memory. While run is high it repeats this scan:
//   1. Capture the raw inputs (SAMPLE).
//   2. Present each instruction in turn, one per clock (ISSUE).
//   3. Pulse scan_done, then wait SCAN_GAP idle cycles (GAP).
//
// Optional feature:
//   VSLC_SEQ_END_OPCODE_EN  When defined, instruction 8'hFF is an end marker.
//                           It is not issued and it ends the scan early.
//                           When not defined, 8'hFF is issued like any other
//                           instruction.
//
// Parameters:
//   SCAN_GAP      idle cycles between consecutive scans (0..255)
//
// Ports:
//   clk           clock; all state updates on posedge
//   rst           asynchronous, active-high reset
//   run           level; high requests continuous scanning
//   prog_we       program-memory write strobe (honoured only in IDLE)
//   prog_addr     program-memory write address
//   prog_data     program-memory write data
//   prog_len      program length; 0 = empty, values above 16 act as 16
//   ui_in         raw inputs
//   instr         instruction presented to the executor (8'h00 when idle)
//   instr_ready   high exactly while instr is valid
//   ui_in_snap    inputs captured at the start of the current scan
//   ui_in_prev    inputs captured at the start of the previous scan
//   pc            index of the instruction being presented
//   scan_done     one-cycle pulse after the last instruction of a scan
//   scan_count    completed-scan counter, wraps 255 -> 0
// ---------------------------------------------------------------------------
module tt_um_jimktrains_vslc_sequencer #(
  parameter int SCAN_GAP = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       prog_we,
  input  logic [3:0] prog_addr,
  input  logic [7:0] prog_data,
  input  logic [4:0] prog_len,
  input  logic [7:0] ui_in,
  output logic [7:0] instr,
  output logic       instr_ready,
  output logic [7:0] ui_in_snap,
  output logic [7:0] ui_in_prev,
  output logic [3:0] pc,
  output logic       scan_done,
  output logic [7:0] scan_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    ISSUE  = 2'd2,
    GAP    = 2'd3
  } state_t;

  localparam logic [7:0] GAP_LOAD = 8'(SCAN_GAP);

`ifdef VSLC_SEQ_END_OPCODE_EN
  localparam bit END_OPCODE_EN = 1'b1;
`else
  localparam bit END_OPCODE_EN = 1'b0;
`endif

  // Clamp a requested program length to the 16-word memory.
  function automatic logic [4:0] clamp_len(input logic [4:0] len);
    return (len > 5'd16) ? 5'd16 : len;
  endfunction

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  mem [16];
  logic [4:0]  len_lat;
  logic [7:0]  gap_cnt;
  logic [4:0]  len_now;
  logic [7:0]  cur_word;
  logic        is_end;
  logic        last_pc;
  logic        scan_end;

  assign len_now  = clamp_len(prog_len);
  assign cur_word = mem[pc];
  assign is_end   = END_OPCODE_EN && (cur_word == 8'hFF);

  // The ">=" form also closes a scan whose latched length is 0. This can
  // happen when prog_len is cleared during SAMPLE. Such a scan issues
  // mem[0] once and then finishes normally, so pc never runs away.
  assign last_pc  = (({1'b0, pc} + 5'd1) >= len_lat);
  assign scan_end = (state == ISSUE) && (is_end || last_pc);

  // The executor-facing outputs depend only on registered state, so they
  // stay stable for the whole clock period.
  assign instr_ready = (state == ISSUE) && !is_end;
  assign instr       = instr_ready ? cur_word : 8'h00;

  // GAP always holds for GAP_LOAD+1 cycles. The first of those cycles is
  // the scan_done wind-down cycle. The rest are the programmed idle gap.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (run && (len_now != 5'd0)) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = ISSUE;
      ISSUE:   if (scan_end) state_nxt = GAP;
      GAP:     if (gap_cnt == 8'd0)
                 state_nxt = (run && (len_now != 5'd0)) ? SAMPLE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= 4'd0;
      len_lat    <= 5'd0;
      gap_cnt    <= 8'd0;
      scan_done  <= 1'b0;
      scan_count <= 8'd0;
      ui_in_snap <= 8'h00;
      ui_in_prev <= 8'h00;
      for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
    end else begin
      state     <= state_nxt;
      scan_done <= scan_end;
      if (scan_end) scan_count <= scan_count + 8'd1;
      case (state)
        IDLE: begin
          if (prog_we) mem[prog_addr] <= prog_data;
        end
        SAMPLE: begin
          ui_in_prev <= ui_in_snap;
          ui_in_snap <= ui_in;
          pc         <= 4'd0;
          len_lat    <= len_now;
        end
        ISSUE: begin
          if (scan_end) gap_cnt <= GAP_LOAD;
          else          pc      <= pc + 4'd1;
        end
        GAP: begin
          if (gap_cnt != 8'd0) gap_cnt <= gap_cnt - 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tt_um_jimktrains_vslc_sequencer.sv
module tb_tt_um_jimktrains_vslc_sequencer;

  localparam int GAP = 2;
`ifdef VSLC_SEQ_END_OPCODE_EN
  localparam bit END_EN = 1'b1;
`else
  localparam bit END_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic       prog_we = 1'b0;
  logic [3:0] prog_addr = 4'd0;
  logic [7:0] prog_data = 8'h00;
  logic [4:0] prog_len = 5'd0;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] instr;
  logic       instr_ready;
  logic [7:0] ui_in_snap;
  logic [7:0] ui_in_prev;
  logic [3:0] pc;
  logic       scan_done;
  logic [7:0] scan_count;

  tt_um_jimktrains_vslc_sequencer #(.SCAN_GAP(GAP)) dut (
    .clk(clk), .rst(rst), .run(run), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .prog_len(prog_len),
    .ui_in(ui_in), .instr(instr), .instr_ready(instr_ready),
    .ui_in_snap(ui_in_snap), .ui_in_prev(ui_in_prev), .pc(pc),
    .scan_done(scan_done), .scan_count(scan_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: a per-scan script of cycles ----------
  typedef struct packed {
    logic       rdy;
    logic [7:0] ins;
    logic [3:0] pc;
    logic       done;
  } exp_t;

  exp_t       q[$];
  exp_t       cur = '0;
  bit         cur_idle = 1'b1;
  bit         cur_sample = 1'b0;
  logic [7:0] m_mem [16];
  logic [7:0] m_snap = 8'h00;
  logic [7:0] m_prev = 8'h00;
  int         m_count = 0;

  function automatic int eff_len(input logic [4:0] l);
    return (l > 5'd16) ? 16 : int'(l);
  endfunction

  always @(posedge clk) begin : model
    int n;
    if (rst) begin
      for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
      m_snap = 8'h00; m_prev = 8'h00; m_count = 0;
      q.delete();
      cur = '0; cur_idle = 1'b1; cur_sample = 1'b0;
    end else begin
      if (cur_idle && prog_we) m_mem[prog_addr] = prog_data;
      if (cur_sample) begin
        // Build the whole scan: the issued words, one done cycle, then the gap.
        n = eff_len(prog_len);
        if (n == 0) n = 1;
        m_prev = m_snap;
        m_snap = ui_in;
        for (int i = 0; i < n; i++) begin
          if (END_EN && m_mem[i] == 8'hFF) begin
            q.push_back('{1'b0, 8'h00, 4'(i), 1'b0});
            break;
          end
          q.push_back('{1'b1, m_mem[i], 4'(i), 1'b0});
        end
        q.push_back('{1'b0, 8'h00, 4'd0, 1'b1});
        for (int g = 0; g < GAP; g++) q.push_back('0);
      end
      cur_sample = 1'b0;
      cur_idle = 1'b0;
      if (q.size() > 0) begin
        cur = q.pop_front();
        if (cur.done) m_count = (m_count + 1) % 256;
      end else if (run && eff_len(prog_len) != 0) begin
        cur = '0; cur_sample = 1'b1;
      end else begin
        cur = '0; cur_idle = 1'b1;
      end
    end
  end

  // ---------------- per-cycle comparison against the model ------------------
  always @(negedge clk) begin
    chk("instr_ready", 32'(instr_ready), 32'(cur.rdy));
    chk("instr", 32'(instr), 32'(cur.ins));
    chk("scan_done", 32'(scan_done), 32'(cur.done));
    chk("scan_count", 32'(scan_count), 32'(m_count[7:0]));
    chk("ui_in_snap", 32'(ui_in_snap), 32'(m_snap));
    chk("ui_in_prev", 32'(ui_in_prev), 32'(m_prev));
    if (cur.rdy) chk("pc", 32'(pc), 32'(cur.pc));
  end

  // ---------------- stimulus with literal expectations ----------------------
  task automatic nx();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    nx();
    prog_we = 1'b0;
  endtask

  task automatic wait_rdy(input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      nx();
      if (instr_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    // Reset state
    nx();
    chk("rst_ready", 32'(instr_ready), 32'd0);
    chk("rst_instr", 32'(instr), 32'd0);
    chk("rst_count", 32'(scan_count), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    nx();
    rst = 1'b0;
    nx();

    // Three-instruction program, two scans with different inputs
    wr(4'd0, 8'h01); wr(4'd1, 8'h10); wr(4'd2, 8'h88);
    prog_len = 5'd3; ui_in = 8'hA5; run = 1'b1;
    nx();
    chk("sample_ready", 32'(instr_ready), 32'd0);
    nx();
    chk("s1_ready0", 32'(instr_ready), 32'd1);
    chk("s1_instr0", 32'(instr), 32'h01);
    chk("s1_pc0", 32'(pc), 32'd0);
    chk("s1_snap", 32'(ui_in_snap), 32'hA5);
    chk("s1_prev", 32'(ui_in_prev), 32'h00);
    nx();
    chk("s1_instr1", 32'(instr), 32'h10);
    chk("s1_pc1", 32'(pc), 32'd1);
    ui_in = 8'h3C;
    nx();
    chk("s1_instr2", 32'(instr), 32'h88);
    chk("s1_pc2", 32'(pc), 32'd2);
    nx();
    chk("s1_done", 32'(scan_done), 32'd1);
    chk("s1_done_ready", 32'(instr_ready), 32'd0);
    chk("s1_count", 32'(scan_count), 32'd1);
    wait_rdy("s2");
    chk("s2_snap", 32'(ui_in_snap), 32'h3C);
    chk("s2_prev", 32'(ui_in_prev), 32'hA5);
    chk("s2_instr0", 32'(instr), 32'h01);
    run = 1'b0;
    repeat (10) nx();

    // One-instruction program: ready pattern 1,0(done),0,0,0(SAMPLE),1
    prog_len = 5'd1; run = 1'b1;
    wait_rdy("gap");
    nx(); chk("gap_p1_ready", 32'(instr_ready), 32'd0);
    chk("gap_p1_done", 32'(scan_done), 32'd1);
    nx(); chk("gap_p2_ready", 32'(instr_ready), 32'd0);
    chk("gap_p2_done", 32'(scan_done), 32'd0);
    nx(); chk("gap_p3_ready", 32'(instr_ready), 32'd0);
    nx(); chk("gap_p4_ready", 32'(instr_ready), 32'd0);
    nx(); chk("gap_p5_ready", 32'(instr_ready), 32'd1);
    run = 1'b0;
    repeat (10) nx();

    // Drop run mid-scan; writes during the scan are dropped
    wr(4'd3, 8'h44);
    prog_len = 5'd4; run = 1'b1;
    wait_rdy("trunc");
    nx();
    chk("trunc_pc1", 32'(pc), 32'd1);
    run = 1'b0;
    prog_we = 1'b1; prog_addr = 4'd0; prog_data = 8'hEE;
    nx(); chk("trunc_pc2", 32'(pc), 32'd2); chk("trunc_i2", 32'(instr), 32'h88);
    nx(); chk("trunc_pc3", 32'(pc), 32'd3); chk("trunc_i3", 32'(instr), 32'h44);
    nx(); chk("trunc_done", 32'(scan_done), 32'd1);
    prog_we = 1'b0;
    repeat (6) nx();
    chk("trunc_idle", 32'(instr_ready), 32'd0);
    run = 1'b1;
    wait_rdy("trunc_again");
    chk("mem_kept", 32'(instr), 32'h01);
    run = 1'b0;
    repeat (12) nx();

    // 8'hFF in the middle of the program
    wr(4'd1, 8'hFF);
    run = 1'b1;
    wait_rdy("ff");
    chk("ff_i0", 32'(instr), 32'h01);
    run = 1'b0;
    nx();
    if (END_EN) begin
      chk("ff_end_ready", 32'(instr_ready), 32'd0);
      nx();
      chk("ff_end_done", 32'(scan_done), 32'd1);
    end else begin
      chk("ff_issued", 32'(instr), 32'hFF);
      chk("ff_ready", 32'(instr_ready), 32'd1);
    end
    repeat (12) nx();

    // Reset in the middle of a scan
    run = 1'b1;
    wait_rdy("rstscan");
    nx(); nx();
    rst = 1'b1;
    #1;
    chk("rst_mid_ready", 32'(instr_ready), 32'd0);
    chk("rst_mid_done", 32'(scan_done), 32'd0);
    chk("rst_mid_count", 32'(scan_count), 32'd0);
    nx();
    rst = 1'b0;
    prog_len = 5'd16;
    wait_rdy("rst_after");
    chk("mem_cleared", 32'(instr), 32'h00);
    repeat (16) nx();
    chk("rst_after_count", 32'(scan_count), 32'd1);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 15) == 0) run = ~run;
      prog_we = ($urandom_range(0, 2) == 0);
      prog_addr = 4'($urandom);
      prog_data = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom);
      if ($urandom_range(0, 7) == 0) prog_len = 5'($urandom);
      ui_in = 8'($urandom);
      nx();
    end
    rst = 1'b0; run = 1'b0; prog_we = 1'b0;
    repeat (30) nx();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
